// File: rtl/bus_arbiter.sv
// bus_arbiter: four-master round-robin arbiter, active-low requests and registered grants.
// Define BUS_ARB_TIMEOUT_EN to bound each tenure to TENURE_MAX cycles when others are waiting.
module bus_arbiter #(
  parameter int TENURE_MAX = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  output logic [1:0] owner,
  output logic       busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     r_state;
  logic [1:0] r_owner;
  logic [3:0] r_grant;
  logic       r_busy;

  logic [3:0] w_req;
  logic [3:0] w_reqOthers;
  logic       w_ownerReq;
  logic [2:0] w_pickAll;
  logic [2:0] w_pickOthers;
  logic       w_expired;
  logic       w_take;
  logic       w_goIdle;
  logic [1:0] w_newOwner;

  if (TENURE_MAX < 2 || TENURE_MAX > 256) begin : g_tenureRange
    $error("bus_arbiter: TENURE_MAX must lie in 2..256");
  end

  // Returns {found, index} of the first requester scanning last+1, last+2, last+3, last.
  function automatic logic [2:0] rrPick(input logic [3:0] req, input logic [1:0] last);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!pick[2] && req[idx]) pick = {1'b1, idx};
    end
    return pick;
  endfunction

  assign w_req        = ~{m3_req_, m2_req_, m1_req_, m0_req_};
  assign w_reqOthers  = w_req & ~(4'b0001 << r_owner);
  assign w_ownerReq   = w_req[r_owner];
  assign w_pickAll    = rrPick(w_req, r_owner);
  assign w_pickOthers = rrPick(w_reqOthers, r_owner);

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TENURE_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(TENURE_MAX - 1);

  logic [CW-1:0] r_tenure;

  assign w_expired = (r_tenure == CNT_LAST);

  // Tenure counter restarts with every new grant and saturates at its last value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tenure <= '0;
    end else if (w_take) begin
      r_tenure <= '0;
    end else if (r_state == GRANT && !w_expired) begin
      r_tenure <= r_tenure + 1'b1;
    end
  end
`else
  assign w_expired = 1'b0;
`endif

  always_comb begin
    w_take     = 1'b0;
    w_goIdle   = 1'b0;
    w_newOwner = r_owner;
    case (r_state)
      IDLE: begin
        if (w_pickAll[2]) begin
          w_take     = 1'b1;
          w_newOwner = w_pickAll[1:0];
        end
      end
      GRANT: begin
        if (!w_ownerReq || w_expired) begin
          if (w_pickOthers[2]) begin
            w_take     = 1'b1;
            w_newOwner = w_pickOthers[1:0];
          end else if (!w_ownerReq) begin
            w_goIdle = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Grants and busy are registered together with the state so they never disagree.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_owner <= 2'd3;
      r_grant <= 4'b0000;
      r_busy  <= 1'b0;
    end else if (w_take) begin
      r_state <= GRANT;
      r_owner <= w_newOwner;
      r_grant <= 4'b0001 << w_newOwner;
      r_busy  <= 1'b1;
    end else if (w_goIdle) begin
      r_state <= IDLE;
      r_grant <= 4'b0000;
      r_busy  <= 1'b0;
    end
  end

  assign {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} = ~r_grant;
  assign owner = r_owner;
  assign busy  = r_busy;

endmodule
